// File: rtl/kbd_io_slave.sv
// kbd_io_slave: bus-mapped keyboard scan-byte FIFO with STATUS/CTRL registers and wait-stated ACK.
// Optional interrupt logic is built only when KBD_IO_SLAVE_IRQ_EN is defined.
module kbd_io_slave #(
    parameter logic [31:0] BASE_ADDR = 32'hFFFF_FF00,
    parameter int          DEPTH     = 8,
    parameter int          WAIT      = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Addr,
    input  logic [31:0] Data_O,
    input  logic        WE,
    input  logic        STB,
    output logic [31:0] Data_I,
    output logic        ACK,
    input  logic [7:0]  kbd_data,
    input  logic        kbd_valid,
    output logic        irq
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {IDLE, WAITST, ACKST} state_t;

    state_t        state, nxt;
    logic [3:0]    wcnt;
    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wp, rp;
    logic [CW-1:0] count;
    logic          ovf, sel, empty, full, fire, pop, push, flush, ctrl_wr, ovf_clr, ovf_set;
    logic [1:0]    rsel;
    logic [31:0]   rdata, status, ctrl;
    logic          unused_bits;

    assign sel         = STB & (Addr[31:4] == BASE_ADDR[31:4]);
    assign empty       = count == '0;
    assign full        = count == CW'(DEPTH);
    assign status      = {21'b0, ovf, full, empty, 8'(count)};
    assign unused_bits = ^{Addr[1:0], Data_O[31:11], Data_O[9:2], Data_O[0]};

    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            state <= IDLE;
            wcnt  <= '0;
        end else begin
            state <= nxt;
            wcnt  <= (state == WAITST) ? wcnt + 4'd1 : 4'd0;
        end

    always_comb begin
        nxt = IDLE;
        case (state)
            IDLE:    nxt = sel ? ((WAIT > 0) ? WAITST : ACKST) : IDLE;
            WAITST:  nxt = !sel ? IDLE : (wcnt == 4'(WAIT - 1)) ? ACKST : WAITST;
            default: nxt = IDLE;
        endcase
    end

    // Side effects fire on the edge leaving ACKST; a DATA pop happens only if a valid byte was returned.
    always_comb begin
        rsel    = Addr[3:2];
        fire    = state == ACKST;
        pop     = fire & ~WE & (rsel == 2'd0) & Data_I[31];
        ctrl_wr = fire & WE & (rsel == 2'd2);
        flush   = ctrl_wr & Data_O[1];
        ovf_clr = fire & WE & (rsel == 2'd1) & Data_O[10];
        push    = kbd_valid & ~flush & (~full | pop);
        ovf_set = kbd_valid & ~flush & full & ~pop;
        rdata   = (rsel == 2'd0) ? (empty ? 32'h0 : {1'b1, 23'b0, mem[rp]}) :
                  (rsel == 2'd1) ? status :
                  (rsel == 2'd2) ? ctrl : 32'h0;
    end

    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            ACK    <= 1'b0;
            Data_I <= '0;
        end else begin
            ACK    <= nxt == ACKST;
            Data_I <= (nxt == ACKST && !WE) ? rdata : '0;
        end

    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
            ovf   <= 1'b0;
        end else begin
            wp    <= flush ? '0 : push ? wp + AW'(1) : wp;
            rp    <= flush ? '0 : pop ? rp + AW'(1) : rp;
            count <= flush ? '0 : count + CW'(push) - CW'(pop);
            ovf   <= ovf_set | (ovf & ~ovf_clr);
        end

    always_ff @(posedge clk)
        if (push) mem[wp] <= kbd_data;

`ifdef KBD_IO_SLAVE_IRQ_EN
    logic irq_en;

    assign ctrl = {31'b0, irq_en};

    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            irq_en <= 1'b0;
            irq    <= 1'b0;
        end else begin
            irq_en <= ctrl_wr ? Data_O[0] : irq_en;
            irq    <= irq_en & ~empty;
        end
`else
    assign ctrl = '0;
    assign irq  = 1'b0;
`endif
endmodule
